// File: rtl/if_stage_if.sv
// Instruction-side SRAM-like bus. A request is accepted with inst_addr_ok, and its data returns later with inst_data_ok.
// master = fetch stage, slave = instruction memory.
interface if_stage_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (output inst_req, inst_addr, input  inst_addr_ok, inst_data_ok, inst_rdata);
  modport slave  (input  inst_req, inst_addr, output inst_addr_ok, inst_data_ok, inst_rdata);
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC, one-outstanding fetch FSM, IF/ID register, delay-slot redirect, one-entry hold buffer.
// Optional IF_ADDR_CHECK_EN: misaligned fetch_pc raises o_adel with a nop entry instead of issuing a request.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jrpc,
  input  logic [31:0] jpc,
  if_stage_if.master  ibus,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst,
  output logic        o_adel
);

  typedef enum logic [1:0] {S_REQ = 2'd0, S_WAIT = 2'd1, S_BLOCK = 2'd2} state_e;

  state_e      state_q;
  logic [31:0] fetch_pc_q, req_pc_q, redir_pc_q, hold_pc_q, hold_inst_q;
  logic [31:0] pc_q, inst_q;
  logic        redir_pend_q, valid_q;

  logic        redir, can_load, misalign;
  logic        ld_resp, ld_hold, ld_adel, accept;
  logic [31:0] target_d, next_pc_d;

  assign redir    = valid_q & ~stall & (pcsource != 2'b00);
  assign can_load = ~valid_q | ~stall;

  always_comb begin
    case (pcsource)
      2'b10:   target_d = jrpc;
      2'b11:   target_d = jpc;
      default: target_d = bpc;
    endcase
  end

  // A redirect latched while the delay-slot request was held off takes priority.
  assign next_pc_d = redir_pend_q ? redir_pc_q : (redir ? target_d : fetch_pc_q + 32'd4);

`ifdef IF_ADDR_CHECK_EN
  assign misalign       = (fetch_pc_q[1:0] != 2'b00);
  assign ibus.inst_addr = fetch_pc_q;
`else
  assign misalign       = 1'b0;
  assign ibus.inst_addr = {fetch_pc_q[31:2], 2'b00};
`endif

  assign ibus.inst_req = (state_q == S_REQ) & ~misalign;
  assign accept        = ibus.inst_req & ibus.inst_addr_ok;
  assign ld_resp       = (state_q == S_WAIT) & ibus.inst_data_ok & can_load;
  assign ld_hold       = (state_q == S_BLOCK) & ~stall;
  assign ld_adel       = (state_q == S_REQ) & misalign & can_load;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_REQ;
      fetch_pc_q   <= RESET_PC;
      req_pc_q     <= 32'h0;
      redir_pc_q   <= 32'h0;
      redir_pend_q <= 1'b0;
      hold_pc_q    <= 32'h0;
      hold_inst_q  <= 32'h0;
      valid_q      <= 1'b0;
      pc_q         <= 32'h0;
      inst_q       <= 32'h0;
    end else begin
      case (state_q)
        S_REQ: begin
          if (accept || ld_adel) begin
            fetch_pc_q   <= next_pc_d;
            redir_pend_q <= 1'b0;
            if (accept) begin
              req_pc_q <= fetch_pc_q;
              state_q  <= S_WAIT;
            end
          end else if (redir) begin
            // Request at pc+4 still pending: it becomes the delay slot, target follows.
            redir_pc_q   <= target_d;
            redir_pend_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (redir) fetch_pc_q <= target_d;
          if (ibus.inst_data_ok) begin
            if (can_load) begin
              state_q <= S_REQ;
            end else begin
              hold_pc_q   <= req_pc_q;
              hold_inst_q <= ibus.inst_rdata;
              state_q     <= S_BLOCK;
            end
          end
        end
        S_BLOCK: begin
          if (redir)  fetch_pc_q <= target_d;
          if (!stall) state_q    <= S_REQ;
        end
        default: state_q <= S_REQ;
      endcase

      if (ld_resp) begin
        valid_q <= 1'b1;
        pc_q    <= req_pc_q;
        inst_q  <= ibus.inst_rdata;
      end else if (ld_hold) begin
        valid_q <= 1'b1;
        pc_q    <= hold_pc_q;
        inst_q  <= hold_inst_q;
      end else if (ld_adel) begin
        valid_q <= 1'b1;
        pc_q    <= fetch_pc_q;
        inst_q  <= 32'h0;
      end else if (!stall) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef IF_ADDR_CHECK_EN
  logic adel_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                adel_q <= 1'b0;
    else if (ld_resp | ld_hold) adel_q <= 1'b0;
    else if (ld_adel)           adel_q <= 1'b1;
  end
  assign o_adel = adel_q;
`else
  assign o_adel = 1'b0;
`endif

  assign o_valid = valid_q;
  assign o_pc    = pc_q;
  assign o_inst  = inst_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: zero-wait memory model driven on the falling edge, monitor of entries consumed by ID.
module tb_if_stage;
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk, reset, stall;
  logic [1:0]  pcsource;
  logic [31:0] bpc, jrpc, jpc;
  logic        o_valid, o_adel;
  logic [31:0] o_pc, o_inst;

  if_stage_if ibus();

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .pcsource(pcsource),
    .bpc(bpc), .jrpc(jrpc), .jpc(jpc), .ibus(ibus),
    .o_valid(o_valid), .o_pc(o_pc), .o_inst(o_inst), .o_adel(o_adel)
  );

  int errors = 0;
  int checks = 0;

  logic        mem_ready;
  logic        mem_pend;
  logic [31:0] mem_addr;
  logic [31:0] mon_pc[$];
  logic [31:0] mon_inst[$];
  logic        mon_adel[$];
  logic [31:0] acc_addr[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'h2408, a[15:0] + 16'h0001};
  endfunction

  // Memory: accepts whenever ready, returns data the cycle after acceptance.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      ibus.inst_addr_ok = 1'b0;
      ibus.inst_data_ok = 1'b0;
      ibus.inst_rdata   = 32'h0;
      mem_pend          = 1'b0;
      mem_addr          = 32'h0;
    end else begin
      ibus.inst_data_ok = mem_pend;
      ibus.inst_rdata   = mem_pend ? mem_word(mem_addr) : 32'h0;
      ibus.inst_addr_ok = (ibus.inst_req === 1'b1) && mem_ready;
      mem_pend          = ibus.inst_addr_ok;
      if (ibus.inst_addr_ok) begin
        mem_addr = ibus.inst_addr;
        acc_addr.push_back(ibus.inst_addr);
      end
    end
  end

  // Entries consumed by ID (valid and not stalled at the edge).
  always @(posedge clk) begin
    if (reset === 1'b1 && o_valid === 1'b1 && stall === 1'b0) begin
      mon_pc.push_back(o_pc);
      mon_inst.push_back(o_inst);
      mon_adel.push_back(o_adel);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    reset = 1'b0; stall = 1'b0; pcsource = 2'b00;
    bpc = 32'h0; jrpc = 32'h0; jpc = 32'h0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mon_pc.delete(); mon_inst.delete(); mon_adel.delete(); acc_addr.delete();
    reset = 1'b1;
  endtask

  task automatic run_redirect(input logic [31:0] br_pc, input logic [1:0] src, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      pcsource = (o_valid === 1'b1 && o_pc === br_pc) ? src : 2'b00;
    end
    pcsource = 2'b00;
  endtask

  task automatic test_reset;
    reset = 1'b0; stall = 1'b0; pcsource = 2'b00; mem_ready = 1'b1;
    bpc = 32'h0; jrpc = 32'h0; jpc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ibus.inst_req !== 1'b1) begin errors++; $display("FAIL rst_req: got %b expected 1", ibus.inst_req); end
    checks++; if (ibus.inst_addr !== RST_PC) begin errors++; $display("FAIL rst_addr: got %h expected %h", ibus.inst_addr, RST_PC); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", o_valid); end
    checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected 0", o_pc); end
    checks++; if (o_inst !== 32'h0) begin errors++; $display("FAIL rst_inst: got %h expected 0", o_inst); end
    checks++; if (o_adel !== 1'b0) begin errors++; $display("FAIL rst_adel: got %b expected 0", o_adel); end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid: got %b expected 0", o_valid); end
    checks++; if (ibus.inst_addr !== RST_PC) begin errors++; $display("FAIL async_rst_addr: got %h expected %h", ibus.inst_addr, RST_PC); end
  endtask

  task automatic test_first_fetch;
    logic [31:0] ep [4];
    logic [31:0] ei [4];
    ep = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008, 32'hBFC0_000C};
    ei = '{32'h2408_0001, 32'h2408_0005, 32'h2408_0009, 32'h2408_000D};
    do_reset();
    @(posedge clk); #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL first_early_valid: got %b expected 0", o_valid); end
    @(posedge clk); #1;
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b expected 1", o_valid); end
    checks++; if (o_pc !== 32'hBFC0_0000) begin errors++; $display("FAIL first_pc: got %h expected bfc00000", o_pc); end
    checks++; if (o_inst !== 32'h2408_0001) begin errors++; $display("FAIL first_inst: got %h expected 24080001", o_inst); end
    repeat (8) @(posedge clk); #1;
    checks++; if (mon_pc.size() < 4) begin errors++; $display("FAIL seq_count: got %0d expected >=4", mon_pc.size()); end
    for (int i = 0; i < 4; i++) begin
      if (mon_pc.size() > i) begin
        checks++; if (mon_pc[i] !== ep[i]) begin errors++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, mon_pc[i], ep[i]); end
        checks++; if (mon_inst[i] !== ei[i]) begin errors++; $display("FAIL seq_inst[%0d]: got %h expected %h", i, mon_inst[i], ei[i]); end
      end
    end
  endtask

  task automatic test_stall;
    logic [31:0] p;
    int n;
    do_reset();
    n = 0;
    while (o_valid !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL stall_wait_valid: got %b expected 1", o_valid); end
    p = o_pc;
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++; if (o_valid !== 1'b1 || o_pc !== p) begin errors++; $display("FAIL stall_hold[%0d]: got %b/%h expected 1/%h", c, o_valid, o_pc, p); end
      if (c > 0) begin
        checks++; if (ibus.inst_req !== 1'b0) begin errors++; $display("FAIL stall_block_req[%0d]: got %b expected 0", c, ibus.inst_req); end
      end
    end
    stall = 1'b0;
    @(posedge clk); #1;
    checks++; if (o_valid !== 1'b1 || o_pc !== p + 32'd4) begin errors++; $display("FAIL stall_release: got %b/%h expected 1/%h", o_valid, o_pc, p + 32'd4); end
    checks++; if (o_inst !== mem_word(p + 32'd4)) begin errors++; $display("FAIL stall_parked_inst: got %h expected %h", o_inst, mem_word(p + 32'd4)); end
    repeat (6) @(posedge clk); #1;
    checks++; if (mon_pc.size() < 3) begin errors++; $display("FAIL stall_count: got %0d expected >=3", mon_pc.size()); end
    for (int i = 0; i < 3; i++) begin
      if (mon_pc.size() > i) begin
        checks++; if (mon_pc[i] !== p + 32'(4 * i)) begin errors++; $display("FAIL stall_seq[%0d]: got %h expected %h", i, mon_pc[i], p + 32'(4 * i)); end
      end
    end
  endtask

  task automatic test_branch;
    logic [31:0] ep [8];
    ep = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008, 32'hBFC0_000C,
           32'hBFC0_0010, 32'hBFC0_0014, 32'hBFC0_0100, 32'hBFC0_0104};
    do_reset();
    bpc = 32'hBFC0_0100;
    run_redirect(32'hBFC0_0010, 2'b01, 20);
    checks++; if (mon_pc.size() < 8) begin errors++; $display("FAIL br_count: got %0d expected >=8", mon_pc.size()); end
    for (int i = 0; i < 8; i++) begin
      if (mon_pc.size() > i) begin
        checks++; if (mon_pc[i] !== ep[i]) begin errors++; $display("FAIL br_pc[%0d]: got %h expected %h", i, mon_pc[i], ep[i]); end
      end
    end
    if (mon_inst.size() > 6) begin
      checks++; if (mon_inst[5] !== 32'h2408_0015) begin errors++; $display("FAIL br_slot_inst: got %h expected 24080015", mon_inst[5]); end
      checks++; if (mon_inst[6] !== 32'h2408_0101) begin errors++; $display("FAIL br_tgt_inst: got %h expected 24080101", mon_inst[6]); end
    end
  endtask

  task automatic test_redir_pend;
    logic [31:0] ep [6];
    int hold;
    bit  done;
    ep = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008, 32'hBFC0_000C, 32'hBFC0_0200, 32'hBFC0_0204};
    do_reset();
    jpc = 32'hBFC0_0200;
    hold = 0; done = 1'b0;
    for (int c = 0; c < 22; c++) begin
      @(posedge clk); #1;
      if (hold > 0) begin
        checks++; if (ibus.inst_req !== 1'b1 || ibus.inst_addr !== 32'hBFC0_000C) begin errors++; $display("FAIL pend_held_req: got %b/%h expected 1/bfc0000c", ibus.inst_req, ibus.inst_addr); end
        hold--;
        if (hold == 0) mem_ready = 1'b1;
      end
      pcsource = 2'b00;
      if (!done && o_valid === 1'b1 && o_pc === 32'hBFC0_0008) begin
        pcsource = 2'b11; mem_ready = 1'b0; hold = 4; done = 1'b1;
      end
    end
    checks++; if (mon_pc.size() < 6) begin errors++; $display("FAIL pend_count: got %0d expected >=6", mon_pc.size()); end
    for (int i = 0; i < 6; i++) begin
      if (mon_pc.size() > i) begin
        checks++; if (mon_pc[i] !== ep[i]) begin errors++; $display("FAIL pend_pc[%0d]: got %h expected %h", i, mon_pc[i], ep[i]); end
      end
    end
    if (acc_addr.size() > 4) begin
      checks++; if (acc_addr[4] !== 32'hBFC0_0200) begin errors++; $display("FAIL pend_tgt_addr: got %h expected bfc00200", acc_addr[4]); end
    end
  endtask

  task automatic test_wrap;
    logic [31:0] ep [5];
    ep = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    do_reset();
    jpc = 32'hFFFF_FFFC;
    run_redirect(RST_PC, 2'b11, 14);
    checks++; if (mon_pc.size() < 5) begin errors++; $display("FAIL wrap_count: got %0d expected >=5", mon_pc.size()); end
    for (int i = 0; i < 5; i++) begin
      if (mon_pc.size() > i) begin
        checks++; if (mon_pc[i] !== ep[i]) begin errors++; $display("FAIL wrap_pc[%0d]: got %h expected %h", i, mon_pc[i], ep[i]); end
      end
    end
    if (mon_inst.size() > 3) begin
      checks++; if (mon_inst[2] !== 32'h2408_FFFD) begin errors++; $display("FAIL wrap_inst_top: got %h expected 2408fffd", mon_inst[2]); end
      checks++; if (mon_inst[3] !== 32'h2408_0001) begin errors++; $display("FAIL wrap_inst_zero: got %h expected 24080001", mon_inst[3]); end
    end
    if (acc_addr.size() > 3) begin
      checks++; if (acc_addr[3] !== 32'h0000_0000) begin errors++; $display("FAIL wrap_addr: got %h expected 00000000", acc_addr[3]); end
    end
  endtask

  task automatic test_misalign;
    do_reset();
    jrpc = 32'hBFC0_0102;
    run_redirect(RST_PC, 2'b10, 12);
`ifdef IF_ADDR_CHECK_EN
    checks++; if (acc_addr.size() != 2) begin errors++; $display("FAIL adel_no_req: got %0d requests expected 2", acc_addr.size()); end
    checks++; if (mon_pc.size() < 3) begin errors++; $display("FAIL adel_count: got %0d expected >=3", mon_pc.size()); end
    if (mon_pc.size() > 2) begin
      checks++; if (mon_adel[1] !== 1'b0) begin errors++; $display("FAIL adel_slot: got %b expected 0", mon_adel[1]); end
      checks++; if (mon_adel[2] !== 1'b1) begin errors++; $display("FAIL adel_flag: got %b expected 1", mon_adel[2]); end
      checks++; if (mon_inst[2] !== 32'h0) begin errors++; $display("FAIL adel_inst: got %h expected 0", mon_inst[2]); end
      checks++; if (mon_pc[2] !== 32'hBFC0_0102) begin errors++; $display("FAIL adel_pc: got %h expected bfc00102", mon_pc[2]); end
    end
`else
    checks++; if (acc_addr.size() < 3) begin errors++; $display("FAIL mis_count: got %0d expected >=3", acc_addr.size()); end
    if (acc_addr.size() > 2) begin
      checks++; if (acc_addr[2] !== 32'hBFC0_0100) begin errors++; $display("FAIL mis_addr_forced: got %h expected bfc00100", acc_addr[2]); end
    end
    for (int i = 0; i < mon_adel.size(); i++) begin
      checks++; if (mon_adel[i] !== 1'b0) begin errors++; $display("FAIL mis_adel[%0d]: got %b expected 0", i, mon_adel[i]); end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_branch();
    test_redir_pend();
    test_wrap();
    test_misalign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline. Holds the PC, issues one-outstanding-request fetches on the SRAM-like instruction port, and drives the IF/ID pipeline register (`o_inst`, `o_pc`, `o_valid`) consumed by ID. It applies ID's resolved redirect (`pcsource`, `bpc`, `jrpc`, `jpc`) with one architectural delay slot, and absorbs ID stalls with a one-entry hold buffer.

## Interface
- `RESET_PC`, 32'hBFC0_0000, first fetch address after reset

Ports:
- `clk`  in  1  pipeline clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `stall`  in  1  ID cannot accept; IF/ID register holds
- `pcsource`  in  2  from ID: 00 sequential, 01 `bpc`, 10 `jrpc`, 11 `jpc`
- `bpc`, `jrpc`, `jpc`  in  32 each  redirect targets from ID
- `inst_req`  out  1  fetch request
- `inst_addr`  out  32  fetch address
- `inst_addr_ok`  in  1  request accepted this cycle
- `inst_data_ok`  in  1  read data valid this cycle
- `inst_rdata`  in  32  fetched word
- `o_valid`  out  1  IF/ID entry valid
- `o_pc`  out  32  PC of `o_inst`
- `o_inst`  out  32  instruction to ID
- `o_adel`  out  1  fetch address error (only with `IF_ADDR_CHECK_EN`)

## Operation
- States: REQ (`inst_req`=1, waiting `inst_addr_ok`), WAIT (one request outstanding, waiting `inst_data_ok`), BLOCK (response parked in hold buffer, no new request).
- `fetch_pc` register holds the address of the current/next request; `inst_addr`=`fetch_pc`.
- REQ→WAIT on `inst_addr_ok`; `fetch_pc` advances to `next_pc` in the same edge.
- WAIT on `inst_data_ok`: if `!o_valid || !stall`, load {`fetch`-time PC, `inst_rdata`} into IF/ID and go REQ; else park in hold buffer and go BLOCK.
- BLOCK: on `!stall`, hold buffer → IF/ID, go REQ.
- IF/ID with no new entry and `!stall`: `o_valid` drops to 0.
- Redirect event `redir` = `o_valid && !stall && pcsource!=00`. Target mux per `pcsource` encoding.
- `next_pc` = `redir_pend ? redir_pc : (redir ? target : fetch_pc+4)`; wrap modulo 2^32.
- Delay slot: the fetch already issued or parked when `redir` fires is the delay slot and is delivered normally; the next issued request uses the target.
- If `redir` fires while a request is in REQ not yet accepted at `pc+4`, that request completes as delay slot; target latched in `redir_pc`, `redir_pend`=1, cleared when a request at the target is accepted.
- `redir` and `inst_addr_ok` in the same cycle: `fetch_pc` takes the target directly; no pending flag.
- At most one outstanding request; `inst_req` never asserted in WAIT or BLOCK.

## Timing
- Reset (async, `reset`=0): state REQ, `fetch_pc`=`RESET_PC`, `o_valid`=0, `o_pc`=0, `o_inst`=0, `o_adel`=0, `redir_pend`=0, hold buffer empty; `inst_req`=1, `inst_addr`=`RESET_PC` combinationally during and after reset.
- `inst_req`/`inst_addr` stable until `inst_addr_ok`.
- `inst_data_ok` earliest the cycle after `inst_addr_ok`; fetch-to-`o_valid` latency = memory latency + 1 edge.
- Zero-wait memory (addr_ok every REQ cycle, data_ok next cycle): one instruction per two cycles.
- Reset mid-request: outstanding transaction abandoned; memory is reset by the same signal.

## Configuration
- `IF_ADDR_CHECK_EN` defined: if `fetch_pc[1:0]!=0`, no request issued; next edge loads IF/ID with `o_valid`=1, `o_inst`=0 (nop), `o_pc`=`fetch_pc`, `o_adel`=1; fetching continues at `next_pc`.
- Undefined: `o_adel` tied 0; `inst_addr[1:0]` forced to 00; no check.

## Test plan
- Reset release, memory answers in 1 cycle with 32'h2408_0001 → first `o_valid`=1, `o_pc`=BFC0_0000, `o_inst`=2408_0001; subsequent PCs +4.
- `stall` held 3 cycles while data_ok arrives → IF/ID unchanged, response parked, `inst_req`=0; on release parked word appears next edge, no loss or duplication.
- Branch at BFC0_0010 in ID with `pcsource`=01, `bpc`=BFC0_0100 → delivered sequence 0010, 0014 (delay slot), 0100.
- `redir` while REQ at pc+4 held off (`inst_addr_ok`=0 for 4 cycles) → delay slot fetched, then `jpc` target via `redir_pend`.
- `fetch_pc`=FFFF_FFFC sequential → next address 0000_0000.
- With `IF_ADDR_CHECK_EN`, `jrpc`=BFC0_0102 → entry with `o_adel`=1, `o_inst`=0, `o_pc`=BFC0_0102, no `inst_req` for that address.
